argmax_seq: RTL

- Sequential classifier stage directly downstream of the MNIST bias-add: consumes the NUM signed logits (fetcher output + bias) and picks the winning class.
- Snapshots all scores on a start pulse, scans them one per cycle with a single comparator, then presents a one-hot class vector, binary index and winning score.
- Output feeds the 7-segment class decoder and the top-level ready indicator.

---
 rtl/argmax_seq_if.sv | 33 +++
 rtl/argmax_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/argmax_seq_if.sv
// argmax_seq_if: handshake and result bundle for the argmax classifier stage.
//   start    - single-cycle scan request (master -> slave)
//   scores   - NUM signed logits, valid while start is high (master -> slave)
//   busy     - scan in progress (slave -> master)
//   ready    - result valid, held until the next accepted start (slave -> master)
//   classes  - one-hot winner (slave -> master)
//   index    - binary winner index (slave -> master)
//   max_val  - winning score (slave -> master)
//   margin   - winner minus runner-up, DATA_WIDTH+1 bits (slave -> master)
interface argmax_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM        = 10,
    parameter int unsigned IDX_W      = 4
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] scores [0:NUM-1];
    logic                         busy;
    logic                         ready;
    logic [NUM-1:0]               classes;
    logic [IDX_W-1:0]             index;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [DATA_WIDTH:0]   margin;

    modport master (
        output start, scores,
        input  busy, ready, classes, index, max_val, margin
    );

    modport slave (
        input  start, scores,
        output busy, ready, classes, index, max_val, margin
    );
endinterface

// File: rtl/argmax_seq.sv
// argmax_seq: sequential argmax over NUM signed logits.
// Snapshots the scores on start, scans one per cycle with a single comparator,
// then holds a one-hot class vector, binary index and winning score in DONE.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - argmax_seq_if.slave (start/scores in; busy/ready/classes/index/
//           max_val/margin out)
// Optional feature: define ARGMAX_MARGIN_EN to track the runner-up and report
// margin = max_val - runner_up; otherwise margin is tied to zero.
module argmax_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM        = 10,
    parameter int unsigned IDX_W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    argmax_seq_if.slave  bus
);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]             LAST_CNT = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, next_state;
    logic   load, step, last;

    logic signed [DATA_WIDTH-1:0] snap [NUM];
    logic [IDX_W-1:0]             cnt;
    logic signed [DATA_WIDTH-1:0] best, cand, best_nx;
    logic [IDX_W-1:0]             best_idx, idx_nx;
    logic                         gt;

    logic                         busy_q, ready_q;
    logic [NUM-1:0]               classes_q;
    logic [IDX_W-1:0]             index_q;
    logic signed [DATA_WIDTH-1:0] max_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and control strobes
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (NUM == 1) next_state = DONE;
                    else          next_state = SCAN;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Single comparator: strict greater-than keeps the lowest index on ties
    always_comb begin
        cand    = snap[cnt];
        gt      = (cand > best);
        best_nx = gt ? cand : best;
        idx_nx  = gt ? cnt  : best_idx;
    end

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_WIDTH-1:0] second, second_nx;
    logic signed [DATA_WIDTH:0]   margin_q;

    // Runner-up takes the displaced best, or the candidate if it beats runner-up
    always_comb begin
        if (gt)                  second_nx = best;
        else if (cand > second)  second_nx = cand;
        else                     second_nx = second;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            second   <= '0;
            margin_q <= '0;
        end else if (load) begin
            second <= MOST_NEG;
            if (NUM == 1)
                margin_q <= {bus.scores[0][DATA_WIDTH-1], bus.scores[0]} - {1'b1, MOST_NEG};
            else
                margin_q <= '0;
        end else if (step) begin
            second <= second_nx;
            if (last)
                margin_q <= {best_nx[DATA_WIDTH-1], best_nx} - {second_nx[DATA_WIDTH-1], second_nx};
        end
    end

    assign bus.margin = margin_q;
`else
    assign bus.margin = '0;
`endif

    // Snapshot, scan datapath and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM); i++) snap[i] <= '0;
            cnt       <= '0;
            best      <= '0;
            best_idx  <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            classes_q <= '0;
            index_q   <= '0;
            max_q     <= '0;
        end else if (load) begin
            snap     <= bus.scores;
            best     <= bus.scores[0];
            best_idx <= '0;
            index_q  <= '0;
            if (NUM == 1) begin
                cnt       <= '0;
                busy_q    <= 1'b0;
                ready_q   <= 1'b1;
                classes_q <= NUM'(1);
                max_q     <= bus.scores[0];
            end else begin
                cnt       <= IDX_W'(1);
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
                classes_q <= '0;
                max_q     <= '0;
            end
        end else if (step) begin
            best     <= best_nx;
            best_idx <= idx_nx;
            if (last) begin
                cnt       <= '0;
                busy_q    <= 1'b0;
                ready_q   <= 1'b1;
                index_q   <= idx_nx;
                classes_q <= NUM'(1) << idx_nx;
                max_q     <= best_nx;
            end else begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.classes = classes_q;
    assign bus.index   = index_q;
    assign bus.max_val = max_q;
endmodule
